// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: sequencer state type and command record layout shared by the pulse sequencer files
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_GAP
    } seq_state_t;

    localparam int DEF_NUM_CHANNEL        = 22;
    localparam int DEF_DC_VALUE_WIDTH     = 12;
    localparam int DEF_PULSE_LENGTH_WIDTH = 20;
    localparam int DEF_GAP_WIDTH          = 8;

    // Queue entry, most significant field first: dc_value, length, gap
    typedef struct packed {
        logic [DEF_NUM_CHANNEL*DEF_DC_VALUE_WIDTH-1:0] dc_value;
        logic [DEF_PULSE_LENGTH_WIDTH-1:0]             length;
        logic [DEF_GAP_WIDTH-1:0]                      gap;
    } cmd_t;

    localparam int CMD_WIDTH = $bits(cmd_t);

    // Width of a packed command record for arbitrary field sizes
    function automatic int cmd_width(input int nc, input int dw, input int lw, input int gw);
        return nc * dw + lw + gw;
    endfunction

endpackage

// File: rtl/pulse_cmd_fifo.sv
// pulse_cmd_fifo: synchronous ordered command queue with flush and occupancy count
module pulse_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    // Pointer and occupancy tracking; flush empties the queue in one edge
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/pulse_dac_sequencer.sv
// pulse_dac_sequencer: queues pulse commands and paces their issue to the DAC controller
module pulse_dac_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int NUM_CHANNEL        = 22,
    parameter int DC_VALUE_WIDTH     = 12,
    parameter int PULSE_LENGTH_WIDTH = 20,
    parameter int GAP_WIDTH          = 8,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  flush,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [DC_VALUE_WIDTH*NUM_CHANNEL-1:0] cmd_dc_value,
    input  logic [PULSE_LENGTH_WIDTH-1:0]         cmd_length,
    input  logic [GAP_WIDTH-1:0]                  cmd_gap,
    output logic [DC_VALUE_WIDTH*NUM_CHANNEL-1:0] dc_value_out,
    output logic [PULSE_LENGTH_WIDTH-1:0]         length_out,
    output logic                                  valid_dc_value_out,
    output logic                                  busy,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
    output logic                                  err_zero_length
);

    localparam int DCW = DC_VALUE_WIDTH * NUM_CHANNEL;
    localparam int CW  = cmd_width(NUM_CHANNEL, DC_VALUE_WIDTH, PULSE_LENGTH_WIDTH, GAP_WIDTH);

    seq_state_t                    r_state;
    seq_state_t                    w_next;
    seq_state_t                    w_decide;
    seq_state_t                    w_after_hold;
    logic [PULSE_LENGTH_WIDTH-1:0] r_hold;
    logic [GAP_WIDTH-1:0]          r_gap;
    logic [DCW-1:0]                r_dc;
    logic [PULSE_LENGTH_WIDTH-1:0] r_len;
    logic                          r_err;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_accept;
    logic                          w_push;
    logic                          w_can_issue;
    logic                          w_load;
    logic [CW-1:0]                 w_head;
    logic [DCW-1:0]                w_head_dc;
    logic [PULSE_LENGTH_WIDTH-1:0] w_head_len;
    logic [GAP_WIDTH-1:0]          w_head_gap;

    // A flush cycle refuses new commands and suppresses any issue from the queue being cleared
    assign cmd_ready   = !w_full && !flush;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_push      = w_accept && (cmd_length != '0);
    assign w_can_issue = !w_empty && enable && !flush;
    assign w_load      = w_next == S_ISSUE;

    assign w_head_dc  = w_head[CW-1 -: DCW];
    assign w_head_len = w_head[GAP_WIDTH +: PULSE_LENGTH_WIDTH];
    assign w_head_gap = w_head[GAP_WIDTH-1:0];

    assign w_decide     = w_can_issue ? S_ISSUE : S_IDLE;
    assign w_after_hold = (r_gap != '0) ? S_GAP : w_decide;

    assign dc_value_out       = r_dc;
    assign length_out         = r_len;
    assign valid_dc_value_out = r_state == S_ISSUE;
    assign busy               = r_state != S_IDLE;
    assign err_zero_length    = r_err;

    pulse_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_flush (flush),
        .i_data  ({cmd_dc_value, cmd_length, cmd_gap}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state: ISSUE lasts one cycle, HOLD covers the rest of the pulse, GAP the idle tail
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_decide;
            S_ISSUE: w_next = (r_hold != '0) ? S_HOLD : w_after_hold;
            S_HOLD:  w_next = (r_hold == PULSE_LENGTH_WIDTH'(1)) ? w_after_hold : S_HOLD;
            S_GAP:   w_next = (r_gap == GAP_WIDTH'(1)) ? w_decide : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    // Head is captured on the edge entering ISSUE so the strobe cycle carries its own data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_gap  <= '0;
            r_dc   <= '0;
            r_len  <= '0;
        end else if (w_load) begin
            r_hold <= w_head_len - PULSE_LENGTH_WIDTH'(1);
            r_gap  <= w_head_gap;
            r_dc   <= w_head_dc;
            r_len  <= w_head_len;
        end else begin
            if (r_state == S_HOLD) r_hold <= r_hold - PULSE_LENGTH_WIDTH'(1);
            if (r_state == S_GAP)  r_gap  <= r_gap - GAP_WIDTH'(1);
        end
    end

    // Zero-length commands are consumed by the handshake and reported one cycle later
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_accept && (cmd_length == '0);
    end

endmodule

// File: tb/tb_pulse_dac_sequencer.sv
// tb_pulse_dac_sequencer: directed scenarios plus randomized traffic against a pacing model
module tb_pulse_dac_sequencer;

    localparam int NC  = 22;
    localparam int DW  = 12;
    localparam int LW  = 20;
    localparam int GW  = 8;
    localparam int FD  = 8;
    localparam int DCW = NC * DW;

    typedef struct packed {
        logic [DCW-1:0] dc;
        logic [LW-1:0]  len;
        logic [GW-1:0]  gap;
    } cmd_s;

    logic             clk = 1'b0;
    logic             rst, enable, flush, cmd_valid, cmd_ready;
    logic             valid_dc_value_out, busy, err_zero_length;
    logic [DCW-1:0]   cmd_dc_value, dc_value_out;
    logic [LW-1:0]    cmd_length, length_out;
    logic [GW-1:0]    cmd_gap;
    logic [$clog2(FD):0] fifo_count;

    cmd_s           q[$];
    int             cyc = 0;
    int             next_ok = 0;
    int             checks = 0;
    int             errors = 0;
    int             exp_count = 0;
    logic           exp_valid = 1'b0;
    logic           exp_busy = 1'b0;
    logic           exp_err = 1'b0;
    logic [DCW-1:0] exp_dc = '0;
    logic [LW-1:0]  exp_len = '0;
    logic           seen_ready = 1'b0;
    logic           mdl_ready = 1'b0;

    always #5 clk = ~clk;

    pulse_dac_sequencer #(
        .NUM_CHANNEL        (NC),
        .DC_VALUE_WIDTH     (DW),
        .PULSE_LENGTH_WIDTH (LW),
        .GAP_WIDTH          (GW),
        .FIFO_DEPTH         (FD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .flush              (flush),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_dc_value       (cmd_dc_value),
        .cmd_length         (cmd_length),
        .cmd_gap            (cmd_gap),
        .dc_value_out       (dc_value_out),
        .length_out         (length_out),
        .valid_dc_value_out (valid_dc_value_out),
        .busy               (busy),
        .fifo_count         (fifo_count),
        .err_zero_length    (err_zero_length)
    );

    function automatic logic [DCW-1:0] rep(input logic [DW-1:0] v);
        return {NC{v}};
    endfunction

    // One clock: drive inputs, sample cmd_ready, advance the pacing model, land on the falling edge.
    // Model: a command may issue at edge k once k >= previous issue edge + length + gap.
    task automatic step(input logic v, input logic [DCW-1:0] dc, input logic [LW-1:0] len,
                        input logic [GW-1:0] gap, input logic en, input logic fl, input logic r);
        cmd_s c;
        bit   iss;
        rst = r; enable = en; flush = fl; cmd_valid = v;
        cmd_dc_value = dc; cmd_length = len; cmd_gap = gap;
        #1;
        seen_ready = cmd_ready;
        mdl_ready  = (q.size() < FD) && !fl;
        @(posedge clk);
        if (r) begin
            q.delete();
            next_ok = 0;
            exp_valid = 1'b0; exp_dc = '0; exp_len = '0; exp_busy = 1'b0; exp_err = 1'b0;
        end else begin
            iss = (q.size() > 0) && en && !fl && (cyc >= next_ok);
            exp_valid = iss;
            if (iss) begin
                c = q.pop_front();
                exp_dc = c.dc;
                exp_len = c.len;
                next_ok = cyc + int'(c.len) + int'(c.gap);
            end
            if (fl) q.delete();
            exp_err = v && mdl_ready && (len == '0);
            if (v && mdl_ready && (len != '0)) begin
                c.dc = dc; c.len = len; c.gap = gap;
                q.push_back(c);
            end
            exp_busy = cyc < next_ok;
        end
        exp_count = q.size();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic en);
        step(1'b0, '0, '0, '0, en, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (valid_dc_value_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_dc_value_out); end
        checks++; if (dc_value_out !== '0) begin errors++; $display("FAIL reset_dc got %0h exp 0", dc_value_out); end
        checks++; if (length_out !== '0) begin errors++; $display("FAIL reset_len got %0d exp 0", length_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (err_zero_length !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_zero_length); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_single;
        int strobes, first, busy_n;
        logic [LW-1:0]  l;
        logic [DCW-1:0] d;
        strobes = 0; first = -1; busy_n = 0; l = '0; d = '0;
        step(1'b1, rep(12'hABC), 20'd16, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", seen_ready); end
        checks++; if (valid_dc_value_out !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", valid_dc_value_out); end
        for (int i = 0; i < 40; i++) begin
            idle(1'b1);
            if (valid_dc_value_out === 1'b1) begin
                if (strobes == 0) begin first = i; l = length_out; d = dc_value_out; end
                strobes++;
            end
            if (busy === 1'b1) busy_n++;
        end
        checks++; if (first != 0) begin errors++; $display("FAIL single_latency got %0d exp 0", first); end
        checks++; if (strobes != 1) begin errors++; $display("FAIL single_strobes got %0d exp 1", strobes); end
        checks++; if (l !== 20'd16) begin errors++; $display("FAIL single_len got %0d exp 16", l); end
        checks++; if (d !== rep(12'hABC)) begin errors++; $display("FAIL single_dc got %0h exp %0h", d, rep(12'hABC)); end
        checks++; if (busy_n != 16) begin errors++; $display("FAIL single_busy got %0d exp 16", busy_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        int t[2];
        logic [LW-1:0]  l[2];
        logic [DCW-1:0] d1;
        int strobes, busy_n, bf, bl;
        strobes = 0; busy_n = 0; bf = -1; bl = -1; d1 = '0;
        t[0] = -1; t[1] = -1; l[0] = '0; l[1] = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)      step(1'b1, rep(12'hABC), 20'd4, 8'd2, 1'b1, 1'b0, 1'b0);
            else if (i == 1) step(1'b1, rep(12'hDEF), 20'd3, 8'd0, 1'b1, 1'b0, 1'b0);
            else             idle(1'b1);
            if (valid_dc_value_out === 1'b1) begin
                if (strobes < 2) begin t[strobes] = i; l[strobes] = length_out; end
                if (strobes == 1) d1 = dc_value_out;
                strobes++;
            end
            if (busy === 1'b1) begin busy_n++; if (bf < 0) bf = i; bl = i; end
        end
        checks++; if (strobes != 2) begin errors++; $display("FAIL b2b_strobes got %0d exp 2", strobes); end
        checks++; if (t[0] != 1) begin errors++; $display("FAIL b2b_first got %0d exp 1", t[0]); end
        checks++; if (t[1] - t[0] != 6) begin errors++; $display("FAIL b2b_spacing got %0d exp 6", t[1] - t[0]); end
        checks++; if (l[0] !== 20'd4 || l[1] !== 20'd3) begin errors++; $display("FAIL b2b_len got %0d,%0d exp 4,3", l[0], l[1]); end
        checks++; if (d1 !== rep(12'hDEF)) begin errors++; $display("FAIL b2b_dc got %0h exp %0h", d1, rep(12'hDEF)); end
        checks++; if (busy_n != 9 || bl - bf + 1 != 9) begin errors++; $display("FAIL b2b_busy got %0d span %0d exp 9", busy_n, bl - bf + 1); end
    endtask

    task automatic test_backpressure;
        int rej, acc, bad;
        int lens[$];
        rej = 0; acc = -1; bad = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, rep(DW'(k)), LW'(k), 8'd0, 1'b0, 1'b0, 1'b0);
            if (seen_ready !== 1'b1) rej++;
        end
        checks++; if (rej != 0) begin errors++; $display("FAIL bp_fill_rejects got %0d exp 0", rej); end
        step(1'b1, rep(12'd9), 20'd9, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", seen_ready); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp_count got %0d exp 8", fifo_count); end
        checks++; if (valid_dc_value_out !== 1'b0) begin errors++; $display("FAIL bp_disabled_strobe got %0b exp 0", valid_dc_value_out); end
        for (int i = 0; i < 80; i++) begin
            if (acc < 0) begin
                step(1'b1, rep(12'd9), 20'd9, 8'd0, 1'b1, 1'b0, 1'b0);
                if (seen_ready === 1'b1) acc = i;
            end else idle(1'b1);
            if (valid_dc_value_out === 1'b1) lens.push_back(int'(length_out));
        end
        checks++; if (acc != 1) begin errors++; $display("FAIL bp_accept_step got %0d exp 1", acc); end
        checks++; if (lens.size() != 9) begin errors++; $display("FAIL bp_strobes got %0d exp 9", lens.size()); end
        foreach (lens[j]) if (lens[j] != j + 1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d out-of-order exp 0", bad); end
    endtask

    task automatic test_zero_length;
        int err_n, err_i, strobes;
        int t[2];
        logic [LW-1:0]  l[2];
        logic [DCW-1:0] d1;
        err_n = 0; err_i = -1; strobes = 0; d1 = '0;
        t[0] = -1; t[1] = -1; l[0] = '0; l[1] = '0;
        for (int i = 0; i < 25; i++) begin
            if (i == 0)      step(1'b1, rep(12'h111), 20'd5, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (i == 1) step(1'b1, rep(12'h222), 20'd0, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (i == 2) step(1'b1, rep(12'h333), 20'd3, 8'd0, 1'b1, 1'b0, 1'b0);
            else             idle(1'b1);
            if (err_zero_length === 1'b1) begin err_n++; err_i = i; end
            if (valid_dc_value_out === 1'b1) begin
                if (strobes < 2) begin t[strobes] = i; l[strobes] = length_out; end
                if (strobes == 1) d1 = dc_value_out;
                strobes++;
            end
        end
        checks++; if (err_n != 1 || err_i != 1) begin errors++; $display("FAIL zero_err got %0d at %0d exp 1 at 1", err_n, err_i); end
        checks++; if (strobes != 2) begin errors++; $display("FAIL zero_strobes got %0d exp 2", strobes); end
        checks++; if (l[0] !== 20'd5 || l[1] !== 20'd3) begin errors++; $display("FAIL zero_len got %0d,%0d exp 5,3", l[0], l[1]); end
        checks++; if (t[1] - t[0] != 5) begin errors++; $display("FAIL zero_spacing got %0d exp 5", t[1] - t[0]); end
        checks++; if (d1 !== rep(12'h333)) begin errors++; $display("FAIL zero_dc got %0h exp %0h", d1, rep(12'h333)); end
    endtask

    task automatic test_flush;
        int strobes, busy_n;
        strobes = 0; busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 3) step(1'b1, rep(DW'(i + 1)), 20'd10, 8'd0, 1'b1, 1'b0, 1'b0);
            else if (i == 4) begin
                step(1'b1, rep(12'h444), 20'd7, 8'd0, 1'b1, 1'b1, 1'b0);
                checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", seen_ready); end
                checks++; if (fifo_count !== '0) begin errors++; $display("FAIL flush_count got %0d exp 0", fifo_count); end
            end else idle(1'b1);
            if (i == 3) begin
                checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL flush_precount got %0d exp 2", fifo_count); end
            end
            if (valid_dc_value_out === 1'b1) strobes++;
            if (busy === 1'b1) busy_n++;
        end
        checks++; if (strobes != 1) begin errors++; $display("FAIL flush_strobes got %0d exp 1", strobes); end
        checks++; if (busy_n != 10) begin errors++; $display("FAIL flush_busy got %0d exp 10", busy_n); end
    endtask

    task automatic test_reset_mid_hold;
        int strobes;
        strobes = 0;
        step(1'b1, rep(12'h777), 20'd64, 8'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, rep(12'h888), 20'd8, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);
        checks++; if (busy !== 1'b1 || fifo_count !== 4'd1) begin errors++; $display("FAIL rmh_pre got busy %0b count %0d exp 1 1", busy, fifo_count); end
        step(1'b1, rep(12'h999), 20'd4, 8'd0, 1'b1, 1'b0, 1'b1);
        checks++; if (valid_dc_value_out !== 1'b0) begin errors++; $display("FAIL rmh_valid got %0b exp 0", valid_dc_value_out); end
        checks++; if (dc_value_out !== '0 || length_out !== '0) begin errors++; $display("FAIL rmh_data got %0h/%0d exp 0/0", dc_value_out, length_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmh_busy got %0b exp 0", busy); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rmh_count got %0d exp 0", fifo_count); end
        for (int i = 0; i < 80; i++) begin
            idle(1'b1);
            if (valid_dc_value_out === 1'b1) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL rmh_ghost got %0d exp 0", strobes); end
        step(1'b1, rep(12'h5A5), 20'd5, 8'd1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        checks++; if (valid_dc_value_out !== 1'b1 || length_out !== 20'd5) begin errors++; $display("FAIL rmh_fresh got %0b/%0d exp 1/5", valid_dc_value_out, length_out); end
        checks++; if (dc_value_out !== rep(12'h5A5)) begin errors++; $display("FAIL rmh_fresh_dc got %0h exp %0h", dc_value_out, rep(12'h5A5)); end
        for (int i = 0; i < 10; i++) idle(1'b1);
    endtask

    task automatic test_random;
        logic [DCW-1:0] dc;
        logic [LW-1:0]  len;
        logic [GW-1:0]  gap;
        logic           v, en, fl, r;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NC; c++) dc[c*DW +: DW] = DW'($urandom);
            v   = $urandom_range(0, 9) < 6;
            len = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 10));
            gap = GW'($urandom_range(0, 4));
            en  = $urandom_range(0, 9) != 0;
            fl  = $urandom_range(0, 49) == 0;
            r   = $urandom_range(0, 299) == 0;
            step(v, dc, len, gap, en, fl, r);
            checks++; if (seen_ready !== mdl_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, seen_ready, mdl_ready); end
            checks++; if (valid_dc_value_out !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", cyc, valid_dc_value_out, exp_valid); end
            checks++; if (length_out !== exp_len) begin errors++; $display("FAIL rnd_len cyc %0d got %0d exp %0d", cyc, length_out, exp_len); end
            checks++; if (dc_value_out !== exp_dc) begin errors++; $display("FAIL rnd_dc cyc %0d got %0h exp %0h", cyc, dc_value_out, exp_dc); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %0b exp %0b", cyc, busy, exp_busy); end
            checks++; if (int'(fifo_count) != exp_count) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, fifo_count, exp_count); end
            checks++; if (err_zero_length !== exp_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", cyc, err_zero_length, exp_err); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_zero_length;
        test_flush;
        test_reset_mid_hold;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
